// File: rtl/noc_pkg.sv
// Shared NoC definitions: flits-per-packet helper, depacketizer state encoding and
// router port indices.
package noc_pkg;

    localparam int PACKET_SIZE_DEFAULT = 32;
    localparam int FLIT_SIZE_DEFAULT   = 4;

    function automatic int calc_fpp(input int packet_size, input int flit_size);
        return packet_size / flit_size;
    endfunction

    localparam int FPP = calc_fpp(PACKET_SIZE_DEFAULT, FLIT_SIZE_DEFAULT);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } depack_state_t;

    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int SOUTH = 2;
    localparam int EAST  = 3;
    localparam int WEST  = 4;

endpackage

// File: rtl/packet_fifo.sv
// Synchronous DEPTH x WIDTH packet buffer with a combinational head output.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module packet_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_dout    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/local_depacketizer.sv
// Reassembles MSB-first flits from the router local port into packets and buffers them
// for the neuron. Optional statistics counters are enabled by LOCAL_SINK_STATS_EN.
module local_depacketizer
    import noc_pkg::*;
#(
    parameter int packet_size = 32,
    parameter int flit_size   = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [flit_size-1:0]   i_flit_in,
    input  logic                   i_write_req,
    output logic                   o_local_neuron_full,
    output logic [packet_size-1:0] o_packet_out,
    output logic                   o_packet_valid,
    input  logic                   i_packet_ready,
    output logic [CNT_WIDTH-1:0]   o_pkt_count,
    output logic [CNT_WIDTH-1:0]   o_drop_count
);

    localparam int LOCAL_FPP = calc_fpp(packet_size, flit_size);
    localparam int IDX_W     = (LOCAL_FPP > 1) ? $clog2(LOCAL_FPP) : 1;
    localparam int BASE_W    = $clog2(packet_size);
    localparam int FCNT_W    = $clog2(FIFO_DEPTH) + 1;

    localparam logic [0:0]       S_COLLECT = COLLECT;
    localparam logic [0:0]       S_HOLD    = HOLD;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LOCAL_FPP - 1);

    logic [0:0]             r_state;
    logic [IDX_W-1:0]       r_flit_idx;
    logic [packet_size-1:0] r_assembly;
    logic [packet_size-1:0] w_next_asm;
    logic [BASE_W-1:0]      w_base;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_space;
    logic                   w_pop;
    logic                   w_push;
    logic [packet_size-1:0] w_push_data;
    logic [FCNT_W-1:0]      w_fifo_count;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;

    // Flit k lands below the previously received flits, so the first flit ends up in the MSBs.
    always_comb begin
        w_base     = BASE_W'(packet_size - (int'(r_flit_idx) + 1) * flit_size);
        w_next_asm = r_assembly;
        w_next_asm[w_base +: flit_size] = i_flit_in;
    end

    assign w_accept    = (r_state == S_COLLECT) & i_write_req;
    assign w_last      = w_accept & (r_flit_idx == LAST_IDX);
    assign w_pop       = i_packet_ready & ~w_fifo_empty;
    assign w_space     = ~w_fifo_full | w_pop;
    assign w_push      = ((r_state == S_HOLD) | w_last) & w_space;
    assign w_push_data = (r_state == S_HOLD) ? r_assembly : w_next_asm;

    assign o_local_neuron_full = (r_state == S_HOLD) | (w_fifo_count == FCNT_W'(FIFO_DEPTH));
    assign o_packet_valid      = ~w_fifo_empty;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_COLLECT;
            r_flit_idx <= '0;
            r_assembly <= '0;
        end else begin
            if (w_accept) begin
                r_assembly <= w_next_asm;
                r_flit_idx <= w_last ? '0 : r_flit_idx + IDX_W'(1);
            end
            if (w_last && !w_space) begin
                r_state <= S_HOLD;
            end else if (r_state == S_HOLD && w_space) begin
                r_state <= S_COLLECT;
            end
        end
    end

    packet_fifo #(
        .WIDTH (packet_size),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_push_data),
        .o_dout  (o_packet_out),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

`ifdef LOCAL_SINK_STATS_EN
    logic [CNT_WIDTH-1:0] r_pkt_count;
    logic [CNT_WIDTH-1:0] r_drop_count;
    logic                 w_drop;

    assign w_drop = (r_state == S_HOLD) & i_write_req;

    // Both counters stick at all ones instead of wrapping.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pkt_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_pop && r_pkt_count != '1) begin
                r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
            end
            if (w_drop && r_drop_count != '1) begin
                r_drop_count <= r_drop_count + CNT_WIDTH'(1);
            end
        end
    end

    assign o_pkt_count  = r_pkt_count;
    assign o_drop_count = r_drop_count;
`else
    assign o_pkt_count  = '0;
    assign o_drop_count = '0;
`endif

endmodule

// File: tb/tb_local_depacketizer.sv
// Scoreboard bench for local_depacketizer: packets are queued as their last flit is sent
// and compared when the neuron side pops them.
module tb_local_depacketizer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  i_flit_in;
    logic        i_write_req;
    logic        o_local_neuron_full;
    logic [31:0] o_packet_out;
    logic        o_packet_valid;
    logic        i_packet_ready;
    logic [7:0]  o_pkt_count;
    logic [7:0]  o_drop_count;

    int          checks   = 0;
    int          errors   = 0;
    int          popCount = 0;
    logic [31:0] sbq[$];
    logic        phase6   = 1'b0;
    logic        sawFull  = 1'b0;

    local_depacketizer #(
        .packet_size (32),
        .flit_size   (4),
        .FIFO_DEPTH  (4),
        .CNT_WIDTH   (8)
    ) dut (
        .i_clk               (clk),
        .i_reset             (reset),
        .i_flit_in           (i_flit_in),
        .i_write_req         (i_write_req),
        .o_local_neuron_full (o_local_neuron_full),
        .o_packet_out        (o_packet_out),
        .o_packet_valid      (o_packet_valid),
        .i_packet_ready      (i_packet_ready),
        .o_pkt_count         (o_pkt_count),
        .o_drop_count        (o_drop_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] expPktCount();
`ifdef LOCAL_SINK_STATS_EN
        return (popCount > 255) ? 32'd255 : 32'(popCount);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] expDropCount(input int drops);
`ifdef LOCAL_SINK_STATS_EN
        return 32'(drops);
`else
        return 32'd0 + 32'(drops * 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one packet MSB-first; an accepted packet is queued for the pop-side compare.
    task automatic applyStimulus(input logic [31:0] data, input logic rdy,
                                 input logic lastRdy, input logic accept);
        for (int k = 0; k < 8; k++) begin
            i_flit_in      = data[31-4*k -: 4];
            i_write_req    = 1'b1;
            i_packet_ready = (k == 7) ? lastRdy : rdy;
            tick();
        end
        i_write_req = 1'b0;
        if (accept) sbq.push_back(data);
    endtask

    task automatic drain(input string tag);
        i_packet_ready = 1'b1;
        for (int c = 0; c < 60 && (sbq.size() > 0 || o_packet_valid); c++) tick();
        i_packet_ready = 1'b0;
        checkOutput({tag, "_validAfterDrain"}, 32'(o_packet_valid), 32'd0);
        checkOutput({tag, "_sbqLeft"}, 32'(sbq.size()), 32'd0);
    endtask

    // Pop-side monitor, sampled mid-cycle so DUT outputs are settled.
    always @(negedge clk) begin
        if (phase6 && o_local_neuron_full) sawFull = 1'b1;
        if (!reset && o_packet_valid && i_packet_ready) begin
            if (sbq.size() == 0) begin
                checkOutput("sbqDepthAtPop", 32'(sbq.size()), 32'd1);
            end else begin
                checkOutput("popData", o_packet_out, sbq.pop_front());
                popCount++;
            end
        end
    end

    initial begin
        logic [31:0] p1;
        reset          = 1'b1;
        i_flit_in      = '0;
        i_write_req    = 1'b0;
        i_packet_ready = 1'b0;
        repeat (2) tick();
        checkOutput("rstValid", 32'(o_packet_valid), 32'd0);
        checkOutput("rstFull",  32'(o_local_neuron_full), 32'd0);
        checkOutput("rstData",  o_packet_out, 32'd0);
        checkOutput("rstPkt",   32'(o_pkt_count), 32'd0);
        checkOutput("rstDrop",  32'(o_drop_count), 32'd0);
        reset = 1'b0;
        tick();

        // Test 1: flits 1..8, valid only after the 8th edge.
        p1 = 32'h12345678;
        for (int k = 0; k < 8; k++) begin
            i_flit_in   = p1[31-4*k -: 4];
            i_write_req = 1'b1;
            tick();
            if (k == 6) checkOutput("t1ValidBeforeLast", 32'(o_packet_valid), 32'd0);
        end
        i_write_req = 1'b0;
        sbq.push_back(p1);
        checkOutput("t1Valid", 32'(o_packet_valid), 32'd1);
        checkOutput("t1Data",  o_packet_out, 32'h12345678);

        // Test 2: fill the FIFO, then a 5th packet goes to HOLD.
        applyStimulus(32'hA1B2C3D4, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h0F1E2D3C, 1'b0, 1'b0, 1'b1);
        checkOutput("t2FullAt3", 32'(o_local_neuron_full), 32'd0);
        applyStimulus(32'h55AA33CC, 1'b0, 1'b0, 1'b1);
        checkOutput("t2FullAt4", 32'(o_local_neuron_full), 32'd1);
        applyStimulus(32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
        checkOutput("t2FullHold", 32'(o_local_neuron_full), 32'd1);
        checkOutput("t2HeadStable", o_packet_out, 32'h12345678);

        // Test 3: three flits offered during HOLD are dropped.
        for (int k = 0; k < 3; k++) begin
            i_flit_in   = 4'h9;
            i_write_req = 1'b1;
            tick();
        end
        i_write_req = 1'b0;
        checkOutput("t3Drop", 32'(o_drop_count), expDropCount(3));
        checkOutput("t3FullStill", 32'(o_local_neuron_full), 32'd1);
        i_packet_ready = 1'b1;
        tick();
        i_packet_ready = 1'b0;
        checkOutput("t3FullAfterSwap", 32'(o_local_neuron_full), 32'd1);
        checkOutput("t3NewHead", o_packet_out, 32'hA1B2C3D4);
        drain("t3");
        checkOutput("t3PktCount", 32'(o_pkt_count), expPktCount());

        // Test 4: pop and push on the same edge keep one packet buffered.
        applyStimulus(32'h600DF00D, 1'b0, 1'b0, 1'b1);
        checkOutput("t4Valid1", 32'(o_packet_valid), 32'd1);
        applyStimulus(32'hC0FFEE11, 1'b0, 1'b1, 1'b1);
        i_packet_ready = 1'b0;
        checkOutput("t4ValidKept", 32'(o_packet_valid), 32'd1);
        checkOutput("t4NewHead", o_packet_out, 32'hC0FFEE11);
        i_packet_ready = 1'b1;
        tick();
        i_packet_ready = 1'b0;
        checkOutput("t4EmptyAfterOnePop", 32'(o_packet_valid), 32'd0);
        checkOutput("t4PktCount", 32'(o_pkt_count), expPktCount());

        // Test 5: reset in the middle of a packet discards the partial flits.
        for (int k = 0; k < 5; k++) begin
            i_flit_in   = 4'(k + 3);
            i_write_req = 1'b1;
            tick();
        end
        i_write_req = 1'b0;
        reset       = 1'b1;
        #2;
        checkOutput("t5RstValid", 32'(o_packet_valid), 32'd0);
        checkOutput("t5RstPkt",   32'(o_pkt_count), 32'd0);
        tick();
        reset    = 1'b0;
        popCount = 0;
        tick();
        applyStimulus(32'hABCDEF01, 1'b0, 1'b0, 1'b1);
        checkOutput("t5Data", o_packet_out, 32'hABCDEF01);
        checkOutput("t5Valid", 32'(o_packet_valid), 32'd1);

        // Test 6: continuous streaming drives pkt_count into saturation.
        i_packet_ready = 1'b1;
        phase6         = 1'b1;
        for (int n = 0; n < 300; n++) begin
            applyStimulus($urandom, 1'b1, 1'b1, 1'b1);
        end
        drain("t6");
        phase6 = 1'b0;
        checkOutput("t6NeverFull", 32'(sawFull), 32'd0);
        checkOutput("t6PopCount", 32'(popCount), 32'd301);
        checkOutput("t6PktSat", 32'(o_pkt_count), expPktCount());
        checkOutput("t6DropAfterRst", 32'(o_drop_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
